// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO pointer type and Gray-code helper
package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;

  // Binary/Gray pointer: one extra MSB distinguishes full from empty
  typedef logic [FIFO_ADDR_W:0] ptr_t;

  // Width-agnostic binary-to-Gray; callers zero-extend and truncate to their pointer width
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// rtl/fifo_gray2bin.sv - combinational Gray-to-binary converter
module fifo_gray2bin #(
  parameter int N = 5
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-side controller; FIFO_RD_LEVEL_EN adds rd_level
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = FIFO_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wr_gptr_async,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_gptr,
  output logic              rd_ack,
  output logic              empty,
  output logic              underflow
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_W:0]   rd_level
`endif
);

  localparam int PTR_W = ADDR_W + 1;

  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] wr_gptr_sync;
  logic [ADDR_W:0] rd_bptr;
  logic [ADDR_W:0] rd_bnext;
  logic [ADDR_W:0] rd_gnext;

  // Multi-flop synchronizer bringing the write pointer into the read clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wr_gptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wr_gptr_sync = sync_q[SYNC_STAGES-1];

  // A read is accepted only when data is known to be present
  assign rd_ack   = rd_en & ~empty;
  assign rd_bnext = rd_bptr + PTR_W'(rd_ack);
  assign rd_gnext = PTR_W'(bin2gray(32'(rd_bnext)));
  assign rd_addr  = rd_bptr[ADDR_W-1:0];

  // Pointer advance and flags; empty looks at the post-read pointer so the last read empties next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bptr   <= '0;
      rd_gptr   <= '0;
      empty     <= 1'b1;
      underflow <= 1'b0;
    end else begin
      rd_bptr   <= rd_bnext;
      rd_gptr   <= rd_gnext;
      empty     <= (rd_gnext == wr_gptr_sync);
      underflow <= rd_en & empty;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR_W:0] wr_bptr_sync;

  fifo_gray2bin #(
    .N (PTR_W)
  ) u_gray2bin (
    .gray (wr_gptr_sync),
    .bin  (wr_bptr_sync)
  );

  // Occupancy as seen by the read side, modulo the extended pointer range
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_level <= '0;
    end else begin
      rd_level <= wr_bptr_sync - rd_bnext;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - randomized self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

  localparam int AW = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic [AW:0]   wr_gptr_async;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_gptr;
  logic          rd_ack;
  logic          empty;
  logic          underflow;
`ifdef FIFO_RD_LEVEL_EN
  logic [AW:0]   rd_level;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: read count, write count, and what the read side can currently see
  logic [AW:0] w;
  logic [AW:0] m_r;
  logic [AW:0] m_level;
  logic        m_empty;
  logic        m_uf;
  logic [AW:0] q[$];

  fifo_rd_ctrl #(
    .ADDR_W      (AW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_en         (rd_en),
    .wr_gptr_async (wr_gptr_async),
    .rd_addr       (rd_addr),
    .rd_gptr       (rd_gptr),
    .rd_ack        (rd_ack),
    .empty         (empty),
    .underflow     (underflow)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level      (rd_level)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_r = '0; m_level = '0; m_empty = 1'b1; m_uf = 1'b0;
    q.delete();
    for (int i = 0; i < SS; i++) q.push_back('0);
  endtask

  // One clock: drive inputs, check the combinational ack, advance the model, check registered outputs
  task automatic step(input logic r_en, input logic [AW:0] wbin, input logic rs);
    logic        ack;
    logic [AW:0] vis;
    logic [AW:0] rn;
    @(negedge clk);
    rd_en = r_en; wr_gptr_async = gray(wbin); rst = rs;
    #1;
    ack = r_en & ~m_empty;
    check("rd_ack", rd_ack, ack);
    if (rs) begin
      model_reset();
    end else begin
      vis     = q[SS-1];
      rn      = m_r + (ack ? 1 : 0);
      m_uf    = r_en & m_empty;
      m_empty = (rn == vis);
      m_level = vis - rn;
      m_r     = rn;
      q.push_front(wbin);
      void'(q.pop_back());
    end
    @(posedge clk);
    #1;
    check("rd_addr", rd_addr, m_r[AW-1:0]);
    check("rd_gptr", rd_gptr, gray(m_r));
    check("empty", empty, m_empty);
    check("underflow", underflow, m_uf);
`ifdef FIFO_RD_LEVEL_EN
    check("rd_level", rd_level, m_level);
`endif
  endtask

  task automatic do_reset();
    w = '0;
    step(1'b0, w, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    logic [AW:0] occ;
    rst = 1'b1; rd_en = 1'b0; wr_gptr_async = '0; w = '0;
    model_reset();

    // Reset state
    do_reset();
    do_reset();
    check("rst_empty", empty, 1);
    check("rst_gptr", rd_gptr, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_uf", underflow, 0);
`ifdef FIFO_RD_LEVEL_EN
    check("rst_level", rd_level, 0);
`endif

    // Underflow while empty
    step(1'b1, w, 1'b0);
    check("uf_addr", rd_addr, 0);
    check("uf_pulse", underflow, 1);
    step(1'b0, w, 1'b0);
    check("uf_clear", underflow, 0);

    // Synchronizer latency: empty falls on the third edge
    do_reset();
    w = 5'd1;
    step(1'b0, w, 1'b0);
    check("lat_e1", empty, 1);
    step(1'b0, w, 1'b0);
    check("lat_e2", empty, 1);
    step(1'b0, w, 1'b0);
    check("lat_e3", empty, 0);
`ifdef FIFO_RD_LEVEL_EN
    check("lat_level", rd_level, 1);
`endif

    // Full occupancy then drain with address wrap
    do_reset();
    w = 5'd16;
    for (int i = 0; i < 3; i++) step(1'b0, w, 1'b0);
`ifdef FIFO_RD_LEVEL_EN
    check("full_level", rd_level, 16);
`endif
    for (int i = 0; i < 16; i++) begin
      check("drain_addr", rd_addr, i);
      check("drain_ne", empty, 0);
      step(1'b1, w, 1'b0);
    end
    check("drain_empty", empty, 1);
    check("drain_wrap", rd_addr, 0);
    check("drain_gptr", rd_gptr, 32'h18);

    // Wrap both pointers past 31 -> 0
    w = 5'd0;
    for (int i = 0; i < 3; i++) step(1'b0, w, 1'b0);
`ifdef FIFO_RD_LEVEL_EN
    check("wrap_level", rd_level, 16);
`endif
    for (int i = 0; i < 16; i++) step(1'b1, w, 1'b0);
    check("wrap_empty", empty, 1);
    check("wrap_gptr", rd_gptr, 0);

    // Reset mid-stream with rd_en held
    do_reset();
    w = 5'd16;
    for (int i = 0; i < 3; i++) step(1'b0, w, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, w, 1'b0);
    check("mid_addr5", rd_addr, 5);
    w = '0;
    step(1'b1, w, 1'b1);
    check("mid_addr", rd_addr, 0);
    check("mid_empty", empty, 1);
    check("mid_noack", rd_ack, 0);
    step(1'b1, w, 1'b0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        occ = w - m_r;
        if (occ < 5'd16 && ($urandom_range(0, 2) != 0)) w = w + 1'b1;
        step(($urandom_range(0, 2) != 0), w, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
